// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encoding and default widths.
package mem_port_arbiter_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_AW      = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2,
    RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Counts BUSY cycles from a start pulse; expired fires in the last allowed cycle without ready.
module bus_watchdog
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ready,
  output logic expired
);

  logic [7:0] cnt;
  logic       active;

  // Counter equals the BUSY-cycle index, so the TIMEOUT-th cycle is cnt == TIMEOUT-1.
  assign expired = active && !ready && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 8'd0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= 8'd0;
      active <= 1'b1;
    end else if (active) begin
      if (ready || expired) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one single-port memory; memory stage wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [W-1:0]  if_rdata,
  output logic          if_valid,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_wdata,
  output logic [W-1:0]  mem_rdata,
  output logic          mem_done,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [W-1:0]  m_wdata,
  input  logic [W-1:0]  m_rdata,
  input  logic          m_ready,
  output logic          stall_fetch,
  output logic          stall_pipe,
  output logic          err
);

  state_t state;
  logic   mem_any;
  logic   start;
  logic   expired;

  assign mem_any     = mem_rd | mem_wr;
  assign start       = (state == IDLE) && (mem_any || if_req);
  assign stall_pipe  = mem_any & ~mem_done;
  assign stall_fetch = stall_pipe | (if_req & ~if_valid);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (m_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      err       <= 1'b0;
      m_en      <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      m_en     <= 1'b0;
      if_valid <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_any) begin
            state   <= MEM_BUSY;
            m_en    <= 1'b1;
            m_we    <= mem_wr;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
          end else if (if_req) begin
            state   <= IF_BUSY;
            m_en    <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            m_wdata <= '0;
          end
        end
        IF_BUSY, MEM_BUSY: begin
          // Response pulse and data are registered on the exit edge so they appear in RESP.
          if (m_ready || expired) begin
            state   <= RESP;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            if (!m_ready) err <= 1'b1;
            if (state == IF_BUSY) begin
              if_valid <= 1'b1;
              if_rdata <= m_ready ? m_rdata : '0;
            end else begin
              mem_done  <= 1'b1;
              mem_rdata <= (m_ready && !m_we) ? m_rdata : '0;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
